// File: rtl/axi4_error_responder_if.sv
// AXI4 subordinate-side bus bundle for the error responder (AW/W/B/AR/R channels).
// The slave modport is the responder's view; the master modport is the requester's.
interface axi4_error_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 64
);
  logic [ID_WIDTH-1:0]   s_awid;
  logic [ADDR_WIDTH-1:0] s_awaddr;
  logic                  s_awvalid;
  logic                  s_awready;
  logic                  s_wvalid;
  logic                  s_wlast;
  logic                  s_wready;
  logic [ID_WIDTH-1:0]   s_bid;
  logic [1:0]            s_bresp;
  logic                  s_bvalid;
  logic                  s_bready;
  logic [ID_WIDTH-1:0]   s_arid;
  logic [ADDR_WIDTH-1:0] s_araddr;
  logic [7:0]            s_arlen;
  logic                  s_arvalid;
  logic                  s_arready;
  logic [ID_WIDTH-1:0]   s_rid;
  logic [DATA_WIDTH-1:0] s_rdata;
  logic [1:0]            s_rresp;
  logic                  s_rlast;
  logic                  s_rvalid;
  logic                  s_rready;

  modport slave (
    input  s_awid, s_awaddr, s_awvalid,
    output s_awready,
    input  s_wvalid, s_wlast,
    output s_wready,
    output s_bid, s_bresp, s_bvalid,
    input  s_bready,
    input  s_arid, s_araddr, s_arlen, s_arvalid,
    output s_arready,
    output s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
    input  s_rready
  );

  modport master (
    output s_awid, s_awaddr, s_awvalid,
    input  s_awready,
    output s_wvalid, s_wlast,
    input  s_wready,
    input  s_bid, s_bresp, s_bvalid,
    output s_bready,
    output s_arid, s_araddr, s_arlen, s_arvalid,
    input  s_arready,
    input  s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
    output s_rready
  );
endinterface

// File: rtl/axi4_error_responder.sv
// AXI4 default subordinate: ends every routed transaction with SLVERR/DECERR; B one cycle after WLAST, first R beat one cycle after AR.
// Valid/ready throughout; outputs hold while ready is low. Optional error counters under ERR_RESP_CNT_EN.
module axi4_error_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  aclk,
  input  logic                  areset,
  axi4_error_responder_if.slave s_axi,
  input  logic                  aw_slverr,
  input  logic                  ar_slverr,
  output logic [15:0]           wr_err_count,
  output logic [15:0]           rd_err_count
);

  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
  typedef enum logic       {R_IDLE, R_DATA} rd_state_e;

  wr_state_e           wr_state_q, wr_state_d;
  logic [ID_WIDTH-1:0] bid_q, bid_d;
  logic [1:0]          bresp_q, bresp_d;

  rd_state_e           rd_state_q, rd_state_d;
  logic [ID_WIDTH-1:0] rid_q, rid_d;
  logic [7:0]          rlen_q, rlen_d;
  logic [7:0]          beat_q, beat_d;
  logic [1:0]          rresp_q, rresp_d;

  // Addresses carry no meaning here: every access that arrives is an error.
  logic unused_addr;
  assign unused_addr = ^{s_axi.s_awaddr, s_axi.s_araddr};

  always_comb begin
    wr_state_d      = wr_state_q;
    bid_d           = bid_q;
    bresp_d         = bresp_q;
    s_axi.s_awready = 1'b0;
    s_axi.s_wready  = 1'b0;
    s_axi.s_bvalid  = 1'b0;
    unique case (wr_state_q)
      W_IDLE: begin
        s_axi.s_awready = 1'b1;
        if (s_axi.s_awvalid) begin
          bid_d      = s_axi.s_awid;
          bresp_d    = aw_slverr ? RESP_SLVERR : RESP_DECERR;
          wr_state_d = W_DATA;
        end
      end
      W_DATA: begin
        s_axi.s_wready = 1'b1;
        if (s_axi.s_wvalid && s_axi.s_wlast) begin
          wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        s_axi.s_bvalid = 1'b1;
        if (s_axi.s_bready) begin
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_state_q <= W_IDLE;
      bid_q      <= '0;
      bresp_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      bid_q      <= bid_d;
      bresp_q    <= bresp_d;
    end
  end

  assign s_axi.s_bid   = bid_q;
  assign s_axi.s_bresp = bresp_q;

  // The beat counter only advances on non-final beats, so arlen=255 never wraps it.
  always_comb begin
    rd_state_d      = rd_state_q;
    rid_d           = rid_q;
    rlen_d          = rlen_q;
    beat_d          = beat_q;
    rresp_d         = rresp_q;
    s_axi.s_arready = 1'b0;
    s_axi.s_rvalid  = 1'b0;
    s_axi.s_rlast   = 1'b0;
    unique case (rd_state_q)
      R_IDLE: begin
        s_axi.s_arready = 1'b1;
        if (s_axi.s_arvalid) begin
          rid_d      = s_axi.s_arid;
          rlen_d     = s_axi.s_arlen;
          rresp_d    = ar_slverr ? RESP_SLVERR : RESP_DECERR;
          beat_d     = 8'd0;
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        s_axi.s_rvalid = 1'b1;
        s_axi.s_rlast  = (beat_q == rlen_q);
        if (s_axi.s_rready) begin
          if (beat_q == rlen_q) begin
            rd_state_d = R_IDLE;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      rd_state_q <= R_IDLE;
      rid_q      <= '0;
      rlen_q     <= '0;
      beat_q     <= '0;
      rresp_q    <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      rid_q      <= rid_d;
      rlen_q     <= rlen_d;
      beat_q     <= beat_d;
      rresp_q    <= rresp_d;
    end
  end

  assign s_axi.s_rid   = rid_q;
  assign s_axi.s_rresp = rresp_q;
  assign s_axi.s_rdata = '0;

`ifdef ERR_RESP_CNT_EN
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic [15:0] rd_cnt_q, rd_cnt_d;

  // Counters saturate so a long-running error storm never reads back as small.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (s_axi.s_bvalid && s_axi.s_bready && (wr_cnt_q != 16'hFFFF)) begin
      wr_cnt_d = wr_cnt_q + 16'd1;
    end
    if (s_axi.s_rvalid && s_axi.s_rready && s_axi.s_rlast && (rd_cnt_q != 16'hFFFF)) begin
      rd_cnt_d = rd_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign wr_err_count = wr_cnt_q;
  assign rd_err_count = rd_cnt_q;
`else
  assign wr_err_count = '0;
  assign rd_err_count = '0;
`endif

endmodule

// File: tb/tb_axi4_error_responder.sv
// Directed bench for axi4_error_responder: stimulus pushes expected B/R responses,
// a negedge monitor pops and compares them on every handshake.
module tb_axi4_error_responder;
  localparam int AW = 32;
  localparam int IW = 4;
  localparam int DW = 64;
`ifdef ERR_RESP_CNT_EN
  localparam int EXP_WR_CNT = 3;
  localparam int EXP_RD_CNT = 2;
`else
  localparam int EXP_WR_CNT = 0;
  localparam int EXP_RD_CNT = 0;
`endif

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        aw_slverr = 1'b0;
  logic        ar_slverr = 1'b0;
  logic [15:0] wr_err_count;
  logic [15:0] rd_err_count;

  axi4_error_responder_if #(.ADDR_WIDTH(AW), .ID_WIDTH(IW), .DATA_WIDTH(DW)) bus ();

  axi4_error_responder #(.ADDR_WIDTH(AW), .ID_WIDTH(IW), .DATA_WIDTH(DW)) dut (
    .aclk         (aclk),
    .areset       (areset),
    .s_axi        (bus),
    .aw_slverr    (aw_slverr),
    .ar_slverr    (ar_slverr),
    .wr_err_count (wr_err_count),
    .rd_err_count (rd_err_count)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {logic [IW-1:0] id; logic [1:0] resp;} b_exp_t;
  typedef struct packed {logic [IW-1:0] id; logic [1:0] resp; logic last;} r_exp_t;

  b_exp_t exp_b[$];
  r_exp_t exp_r[$];
  int     n_vec = 0;
  int     n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] code(input logic slverr);
    return slverr ? 2'b10 : 2'b11;
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_aw(input logic [IW-1:0] id, input logic slverr);
    b_exp_t e;
    bit     hs = 1'b0;
    e.id   = id;
    e.resp = code(slverr);
    exp_b.push_back(e);
    bus.s_awid    = id;
    bus.s_awaddr  = $urandom;
    aw_slverr     = slverr;
    bus.s_awvalid = 1'b1;
    for (int n = 0; n < 50 && !hs; n++) begin
      @(negedge aclk);
      hs = bus.s_awready;
      tick();
    end
    if (!hs) check("aw_handshake_timeout", 0, 1);
    bus.s_awvalid = 1'b0;
  endtask

  task automatic send_w(input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      bit hs = 1'b0;
      bus.s_wvalid = 1'b1;
      bus.s_wlast  = (b == nbeats - 1);
      for (int n = 0; n < 50 && !hs; n++) begin
        @(negedge aclk);
        hs = bus.s_wready;
        tick();
      end
      if (!hs) check("w_handshake_timeout", 0, 1);
    end
    bus.s_wvalid = 1'b0;
    bus.s_wlast  = 1'b0;
  endtask

  task automatic send_ar(input logic [IW-1:0] id, input logic [7:0] len, input logic slverr,
                         input int npush);
    r_exp_t e;
    bit     hs = 1'b0;
    for (int i = 0; i < npush; i++) begin
      e.id   = id;
      e.resp = code(slverr);
      e.last = (i == int'(len));
      exp_r.push_back(e);
    end
    bus.s_arid    = id;
    bus.s_araddr  = $urandom;
    bus.s_arlen   = len;
    ar_slverr     = slverr;
    bus.s_arvalid = 1'b1;
    for (int n = 0; n < 50 && !hs; n++) begin
      @(negedge aclk);
      hs = bus.s_arready;
      tick();
    end
    if (!hs) check("ar_handshake_timeout", 0, 1);
    bus.s_arvalid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 500 && (exp_b.size() != 0 || exp_r.size() != 0); n++) tick();
    if (exp_b.size() != 0) check("b_drain_timeout", exp_b.size(), 0);
    if (exp_r.size() != 0) check("r_drain_timeout", exp_r.size(), 0);
  endtask

  // Monitor: handshakes are decided by values stable at the falling edge.
  logic       r_hold = 1'b0;
  logic [6:0] r_saved;
  b_exp_t     mb;
  r_exp_t     mr;

  always @(negedge aclk) begin
    if (areset) begin
      r_hold = 1'b0;
    end else begin
      if (r_hold) begin
        check("r_hold_valid", bus.s_rvalid, 1);
        check("r_hold_payload", {bus.s_rid, bus.s_rresp, bus.s_rlast}, r_saved);
      end
      if (bus.s_bvalid && bus.s_bready) begin
        if (exp_b.size() == 0) check("b_unexpected", 1, 0);
        else begin
          mb = exp_b.pop_front();
          check("bid", bus.s_bid, mb.id);
          check("bresp", bus.s_bresp, mb.resp);
        end
      end
      if (bus.s_rvalid && bus.s_rready) begin
        if (exp_r.size() == 0) check("r_unexpected", 1, 0);
        else begin
          mr = exp_r.pop_front();
          check("rid", bus.s_rid, mr.id);
          check("rresp", bus.s_rresp, mr.resp);
          check("rlast", bus.s_rlast, mr.last);
          check("rdata", bus.s_rdata, 0);
        end
      end
      r_hold  = bus.s_rvalid && !bus.s_rready;
      r_saved = {bus.s_rid, bus.s_rresp, bus.s_rlast};
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    bus.s_awid = '0; bus.s_awaddr = '0; bus.s_awvalid = 1'b0;
    bus.s_wvalid = 1'b0; bus.s_wlast = 1'b0; bus.s_bready = 1'b0;
    bus.s_arid = '0; bus.s_araddr = '0; bus.s_arlen = '0; bus.s_arvalid = 1'b0;
    bus.s_rready = 1'b0;
    areset = 1'b1;
    repeat (3) tick();
    areset = 1'b0;

    // Reset state
    @(negedge aclk);
    check("rst_awready", bus.s_awready, 1);
    check("rst_arready", bus.s_arready, 1);
    check("rst_wready", bus.s_wready, 0);
    check("rst_bvalid", bus.s_bvalid, 0);
    check("rst_rvalid", bus.s_rvalid, 0);
    check("rst_rlast", bus.s_rlast, 0);
    check("rst_bid", bus.s_bid, 0);
    check("rst_rid", bus.s_rid, 0);
    check("rst_bresp", bus.s_bresp, 0);
    check("rst_rresp", bus.s_rresp, 0);
    check("rst_rdata", bus.s_rdata, 0);
    check("rst_wr_cnt", wr_err_count, 0);
    check("rst_rd_cnt", rd_err_count, 0);
    tick();

    // Write id=3 DECERR, 4 beats; B held while bready is low
    send_aw(4'd3, 1'b0);
    send_w(4);
    check("b_latency", bus.s_bvalid, 1);
    tick();
    tick();
    @(negedge aclk);
    check("b_hold_valid", bus.s_bvalid, 1);
    check("b_hold_id", bus.s_bid, 3);
    check("b_hold_resp", bus.s_bresp, 2'b11);
    tick();
    bus.s_bready = 1'b1;
    wait_drain();

    // Read id=5 arlen=7 SLVERR, 8 back-to-back beats
    bus.s_rready = 1'b1;
    send_ar(4'd5, 8'd7, 1'b1, 8);
    check("r_first_beat", bus.s_rvalid, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge aclk);
      check("r_consecutive", bus.s_rvalid, 1);
      tick();
    end
    @(negedge aclk);
    check("r_after_last", bus.s_rvalid, 0);
    tick();
    wait_drain();

    // Single-beat read held under backpressure
    bus.s_rready = 1'b0;
    send_ar(4'd9, 8'd0, 1'b0, 1);
    repeat (3) tick();
    bus.s_rready = 1'b1;
    tick();
    @(negedge aclk);
    check("r_single_done", bus.s_rvalid, 0);
    tick();
    wait_drain();

    // W presented before AW must stall; AW and AR in the same cycle
    bus.s_wvalid = 1'b1;
    bus.s_wlast  = 1'b1;
    repeat (2) begin
      @(negedge aclk);
      check("w_stall_before_aw", bus.s_wready, 0);
      tick();
    end
    fork
      send_aw(4'hA, 1'b1);
      send_ar(4'h6, 8'd2, 1'b0, 3);
    join
    check("concurrent_wready", bus.s_wready, 1);
    check("concurrent_rvalid", bus.s_rvalid, 1);
    send_w(1);
    wait_drain();

    // Reset during beat 3 of an arlen=15 burst abandons it
    send_ar(4'd7, 8'd15, 1'b0, 2);
    tick();
    tick();
    areset = 1'b1;
    tick();
    areset = 1'b0;
    check("mid_rst_rvalid", bus.s_rvalid, 0);
    check("mid_rst_arready", bus.s_arready, 1);
    send_ar(4'd8, 8'd1, 1'b1, 2);
    tick();
    tick();
    @(negedge aclk);
    check("r_two_beats_only", bus.s_rvalid, 0);
    tick();
    wait_drain();

    // Error counters: 3 writes and 2 reads after a fresh reset
    areset = 1'b1;
    tick();
    areset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_aw(IW'(i + 1), i[0]);
      send_w(i + 1);
    end
    for (int i = 0; i < 2; i++) send_ar(IW'(i + 12), 8'(i), i[0], i + 1);
    wait_drain();
    tick();
    @(negedge aclk);
    check("wr_err_count", wr_err_count, EXP_WR_CNT);
    check("rd_err_count", rd_err_count, EXP_RD_CNT);
    tick();

    check("b_queue_empty", exp_b.size(), 0);
    check("r_queue_empty", exp_r.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/axi4_error_responder.md
AXI4_ERROR_RESPONDER -- requirements
Module: axi4_error_responder

Interface
REQ-001 Parameters: ADDR_WIDTH, 32, address width (unused internally, kept for port compatibility).
REQ-002 Parameters: ID_WIDTH, 4, AXI ID width.
REQ-003 Parameters: DATA_WIDTH, 64, AXI read data width.
REQ-004 Ports, clock and reset first; one clock, and reset is synchronous and active-high:
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  synchronous, active-high reset.
- s_awid  in  ID_WIDTH  write ID.
- s_awaddr  in  ADDR_WIDTH  write address (ignored).
- s_awvalid  in  1  AW valid.
- s_awready  out  1  AW ready.
- aw_slverr  in  1  1 = permission/security violation (SLVERR); 0 = unmapped (DECERR); sampled at AW handshake.
- s_wvalid  in  1  W valid.
- s_wlast  in  1  W last.
- s_wready  out  1  W ready (W data is discarded).
- s_bid  out  ID_WIDTH  B ID.
- s_bresp  out  2  B response.
- s_bvalid  out  1  B valid.
- s_bready  in  1  B ready.
- s_arid  in  ID_WIDTH  read ID.
- s_araddr  in  ADDR_WIDTH  read address (ignored).
- s_arlen  in  8  burst length minus 1.
- s_arvalid  in  1  AR valid.
- s_arready  out  1  AR ready.
- ar_slverr  in  1  same encoding as aw_slverr; sampled at AR handshake.
- s_rid  out  ID_WIDTH  R ID.
- s_rdata  out  DATA_WIDTH  R data.
- s_rresp  out  2  R response.
- s_rlast  out  1  R last.
- s_rvalid  out  1  R valid.
- s_rready  in  1  R ready.
- wr_err_count  out  16  completed write error transactions.
- rd_err_count  out  16  completed read error transactions.

Function
REQ-005 The block SHALL complete every transaction the decoder routes to it (no slave selected, or access_error) with an error response; the read and write paths SHALL be independent and SHALL run concurrently.
REQ-006 The write FSM SHALL have the states W_IDLE, W_DATA and W_RESP.
- W_IDLE: s_awready=1; on the AW handshake, capture s_awid and the response code, then go to W_DATA.
- W_DATA: s_wready=1; each W beat is accepted and dropped; a beat with s_wvalid && s_wlast goes to W_RESP.
- W_RESP: s_bvalid=1; on s_bready, go to W_IDLE.
REQ-007 s_awready SHALL be 0 outside W_IDLE, and s_wready SHALL be 0 outside W_DATA; W beats presented before the AW handshake SHALL be stalled, not consumed.
REQ-008 s_bvalid SHALL rise on the cycle after the WLAST handshake and SHALL hold, with s_bid and s_bresp stable, until s_bready is sampled high.
REQ-009 Response code: 2'b10 (SLVERR) when the sampled *_slverr=1; otherwise 2'b11 (DECERR).
REQ-010 The read FSM SHALL have the states R_IDLE and R_DATA.
- R_IDLE: s_arready=1; on the AR handshake, capture s_arid, s_arlen and the response code, clear the 8-bit beat counter, then go to R_DATA.
- R_DATA: s_rvalid=1, s_rdata=0, s_rresp=captured code.
- s_rlast=1 exactly when beat counter == captured arlen.
- The counter increments on each s_rvalid && s_rready handshake.
- A handshake with s_rlast set goes to R_IDLE.
REQ-011 The first R beat SHALL be valid on the cycle after the AR handshake; arlen=0 yields a single beat with s_rlast=1; arlen=255 yields 256 beats with no counter overflow before last.
REQ-012 While s_rready=0, s_rvalid and every R payload output SHALL hold stable.
REQ-013 s_arready SHALL be 0 in R_DATA; a new AR SHALL be accepted only after the last beat completes (no outstanding queue).
REQ-014 s_rdata SHALL always be 0.

Reset
REQ-015 While areset=1 at a rising edge, both FSMs SHALL go to their IDLE states, including mid-burst; in-flight transactions are abandoned without a response.
REQ-016 Output values during and after reset:
- s_awready=1, s_arready=1.
- s_wready=0, s_bvalid=0, s_rvalid=0, s_rlast=0.
- s_bid=0, s_rid=0, s_bresp=0, s_rresp=0, s_rdata=0.
- wr_err_count=0, rd_err_count=0.

Configuration
REQ-017 Macro ERR_RESP_CNT_EN, defined:
- wr_err_count SHALL increment on each B handshake.
- rd_err_count SHALL increment on each final R handshake.
- Both counters are 16-bit and saturate at 16'hFFFF.
REQ-018 Macro ERR_RESP_CNT_EN, undefined: both count ports SHALL remain present and be tied to 0, and no counter logic SHALL be built.

Verification
REQ-019 AW id=3 with aw_slverr=0, then 4 W beats, the last with wlast -> bvalid on the cycle after the 4th beat, bid=3, bresp=2'b11.
REQ-020 AR id=5, arlen=7, ar_slverr=1, rready=1 -> 8 beats on consecutive cycles, rid=5, rresp=2'b10, rdata=0, rlast only on beat 8.
REQ-021 AR arlen=0 with rready toggling 0/1 -> single beat held stable until accepted, rlast=1.
REQ-022 Simultaneous AW and AR in the same cycle; W beats presented before AW -> both addresses accepted, no W beat taken before the AW handshake, and both responses correct.
REQ-023 areset asserted on beat 3 of an arlen=15 burst -> next cycle rvalid=0 and arready=1; a following arlen=1 burst returns exactly 2 beats.
REQ-024 With ERR_RESP_CNT_EN defined, 3 writes and 2 reads -> wr_err_count=3 and rd_err_count=2; with the macro undefined, both read 0.
